// File: rtl/mmu_pkg.sv
// Shared types and register-map constants for the MMU register write stage
// and its translation-probe FSM.
package mmu_pkg;

    localparam int unsigned ADR_W    = 32;
    localparam int unsigned DAT_W    = 256;
    localparam int unsigned SEL_W    = 32;
    localparam int unsigned TID_W    = 16;
    localparam int unsigned LANE_W   = 64;
    localparam int unsigned N_LANES  = 4;
    localparam int unsigned N_PBL    = 16;
    localparam int unsigned REGSET_W = 5;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [TID_W-1:0] tid;
    } wb_cmd_request256_t;

    typedef logic [LANE_W-1:0] ptbr_t;
    typedef logic [LANE_W-1:0] ptattr_t;
    typedef logic [LANE_W-1:0] pebble_t;
    typedef logic [LANE_W-1:0] virtual_address_t;
    typedef logic [LANE_W-1:0] physical_address_t;

    typedef enum logic [1:0] {
        PRB_IDLE = 2'd0,
        PRB_REQ  = 2'd1,
        PRB_DONE = 2'd2
    } probe_state_e;

    // Offsets within the register window; blocks are 32 B (pebbles 128 B)
    localparam logic [13:0] OFF_FCLR = 14'h3F00;
    localparam logic [13:0] OFF_PTBR = 14'h3F20;
    localparam logic [13:0] OFF_VADR = 14'h3F40;
    localparam logic [13:0] OFF_RSET = 14'h3F60;
    localparam logic [13:0] OFF_PBL  = 14'h3B00;

    localparam logic [ADR_W-1:0] CFG_SIZE = 32'h0000_2000;
    localparam logic [ADR_W-1:0] REG_SIZE = 32'h0000_4000;

    // Byte-enable merge of one 64-bit lane into an existing value
    function automatic logic [LANE_W-1:0] merge_lane(input logic [LANE_W-1:0] old_v,
                                                     input logic [LANE_W-1:0] new_v,
                                                     input logic [7:0]        be);
        logic [LANE_W-1:0] res;
        res = old_v;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmu_probe_fsm.sv
// Translation probe sequencer: launches a walker request, captures the
// physical address and flags it valid until the next launch.
module mmu_probe_fsm
    import mmu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic              xlat_ack,
    input  physical_address_t xlat_padr,
    output logic              xlat_req,
    output physical_address_t phys_adr,
    output logic              phys_adr_v
);

    probe_state_e      state_q;
    probe_state_e      state_d;
    logic              xlat_req_d;
    physical_address_t phys_adr_d;
    logic              phys_adr_v_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= PRB_IDLE;
            xlat_req   <= 1'b0;
            phys_adr   <= '0;
            phys_adr_v <= 1'b0;
        end else begin
            state_q    <= state_d;
            xlat_req   <= xlat_req_d;
            phys_adr   <= phys_adr_d;
            phys_adr_v <= phys_adr_v_d;
        end
    end

    // Next state; a launch always wins over a coincident walker ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRB_IDLE: if (launch) state_d = PRB_REQ;
            PRB_REQ: begin
                if (launch)        state_d = PRB_REQ;
                else if (xlat_ack) state_d = PRB_DONE;
            end
            PRB_DONE: state_d = launch ? PRB_REQ : PRB_IDLE;
            default:  state_d = PRB_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        xlat_req_d   = xlat_req;
        phys_adr_d   = phys_adr;
        phys_adr_v_d = phys_adr_v;
        case (state_q)
            PRB_REQ: begin
                if (launch) begin
                    xlat_req_d   = 1'b1;
                    phys_adr_v_d = 1'b0;
                end else if (xlat_ack) begin
                    xlat_req_d   = 1'b0;
                    phys_adr_d   = xlat_padr;
                    phys_adr_v_d = 1'b1;
                end
            end
            default: begin
                if (launch) begin
                    xlat_req_d   = 1'b1;
                    phys_adr_v_d = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/mmu_reg_write.sv
// Write stage of the MMU slave port: window selects, write accept/ack,
// register decode with byte-lane merge, and the translation probe.
module mmu_reg_write
    import mmu_pkg::*;
#(
    parameter logic [ADR_W-1:0] CFG_BASE = 32'hFFD0_0000,
    parameter logic [ADR_W-1:0] REG_BASE = 32'hFFD1_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  wb_cmd_request256_t      sreq,
    output logic                    cs_config,
    output logic                    cs_regs,
    output logic                    wr_ack,
    output logic [TID_W-1:0]        wr_tid,
    output ptbr_t                   ptbr,
    output ptattr_t                 ptattr,
    output virtual_address_t        virt_adr,
    output logic [REGSET_W-1:0]     pbl_regset,
    output pebble_t [N_PBL-1:0]     pbl,
    output logic                    fault_clr,
    output logic                    xlat_req,
    input  logic                    xlat_ack,
    input  physical_address_t       xlat_padr,
    output physical_address_t       phys_adr,
    output logic                    phys_adr_v
);

    logic in_cfg, in_reg;
    logic sel_cfg, sel_reg;
    logic held;
    logic accept;
    logic hit_fclr, hit_ptbr, hit_vadr, hit_rset, hit_pbl;
    logic launch;
    logic [LANE_W-1:0] lane [N_LANES];

    // Unsigned wrap makes addresses below the base fall out of range
    assign in_cfg  = (sreq.adr - CFG_BASE) < CFG_SIZE;
    assign in_reg  = (sreq.adr - REG_BASE) < REG_SIZE;
    assign sel_cfg = sreq.cyc & sreq.stb & in_cfg;
    assign sel_reg = sreq.cyc & sreq.stb & in_reg & ~in_cfg;
    assign accept  = sel_reg & sreq.we & ~held;

    always_comb begin
        for (int k = 0; k < int'(N_LANES); k++) begin
            lane[k] = sreq.dat[LANE_W*k +: LANE_W];
        end
    end

    assign hit_fclr = accept && (sreq.adr[13:5] == OFF_FCLR[13:5]);
    assign hit_ptbr = accept && (sreq.adr[13:5] == OFF_PTBR[13:5]);
    assign hit_vadr = accept && (sreq.adr[13:5] == OFF_VADR[13:5]);
    assign hit_rset = accept && (sreq.adr[13:5] == OFF_RSET[13:5]);
    assign hit_pbl  = accept && (sreq.adr[13:7] == OFF_PBL[13:7]);
    assign launch   = hit_vadr && (|sreq.sel[7:0]);

    // Bus handshake: selects, one-shot accept per strobe, ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_config <= 1'b0;
            cs_regs   <= 1'b0;
            held      <= 1'b0;
            wr_ack    <= 1'b0;
            wr_tid    <= '0;
            fault_clr <= 1'b0;
        end else begin
            cs_config <= sel_cfg;
            cs_regs   <= sel_reg;
            if (accept)        held <= 1'b1;
            else if (!sreq.stb) held <= 1'b0;
            wr_ack    <= accept;
            if (accept) wr_tid <= sreq.tid;
            fault_clr <= hit_fclr && (|sreq.sel);
        end
    end

    // Register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptbr       <= '0;
            ptattr     <= '0;
            virt_adr   <= '0;
            pbl_regset <= '0;
            pbl        <= '0;
        end else begin
            if (hit_ptbr) begin
                ptbr   <= merge_lane(ptbr,   lane[1], sreq.sel[15:8]);
                ptattr <= merge_lane(ptattr, lane[3], sreq.sel[31:24]);
            end
            if (launch) begin
                virt_adr <= merge_lane(virt_adr, lane[0], sreq.sel[7:0]);
            end
            if (hit_rset && sreq.sel[8]) begin
                pbl_regset <= lane[1][REGSET_W-1:0];
            end
            if (hit_pbl) begin
                for (int k = 0; k < int'(N_LANES); k++) begin
                    pbl[{sreq.adr[6:5], 2'(k)}] <= merge_lane(pbl[{sreq.adr[6:5], 2'(k)}],
                                                              lane[k],
                                                              sreq.sel[8*k +: 8]);
                end
            end
        end
    end

    mmu_probe_fsm u_probe (
        .clk        (clk),
        .rst        (rst),
        .launch     (launch),
        .xlat_ack   (xlat_ack),
        .xlat_padr  (xlat_padr),
        .xlat_req   (xlat_req),
        .phys_adr   (phys_adr),
        .phys_adr_v (phys_adr_v)
    );

endmodule

// File: tb/tb_mmu_reg_write.sv
// Directed bench for mmu_reg_write: table of register writes with expected
// results, plus hand sequences for probe, strobe hold, config window and reset.
module tb_mmu_reg_write;
    import mmu_pkg::*;

    localparam logic [31:0] CFG_B = 32'hFFD0_0000;
    localparam logic [31:0] REG_B = 32'hFFD1_0000;

    localparam int K_PTBR = 0, K_PTATTR = 1, K_RSET = 2, K_PBL = 3, K_FCLR = 4;

    logic                clk = 1'b0;
    logic                rst;
    wb_cmd_request256_t  sreq;
    logic                cs_config, cs_regs, wr_ack, fault_clr, xlat_req, xlat_ack, phys_adr_v;
    logic [15:0]         wr_tid;
    ptbr_t               ptbr;
    ptattr_t             ptattr;
    virtual_address_t    virt_adr;
    logic [4:0]          pbl_regset;
    pebble_t [15:0]      pbl;
    physical_address_t   xlat_padr, phys_adr;

    int n_total = 0;
    int n_pass  = 0;

    mmu_reg_write #(.CFG_BASE(CFG_B), .REG_BASE(REG_B)) dut (
        .clk(clk), .rst(rst), .sreq(sreq),
        .cs_config(cs_config), .cs_regs(cs_regs),
        .wr_ack(wr_ack), .wr_tid(wr_tid),
        .ptbr(ptbr), .ptattr(ptattr), .virt_adr(virt_adr),
        .pbl_regset(pbl_regset), .pbl(pbl), .fault_clr(fault_clr),
        .xlat_req(xlat_req), .xlat_ack(xlat_ack), .xlat_padr(xlat_padr),
        .phys_adr(phys_adr), .phys_adr_v(phys_adr_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0]  off;
        logic [31:0]  sel;
        logic [255:0] dat;
        int           kind;
        logic [3:0]   idx;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [31:0] adr, input logic [31:0] sel,
                            input logic [255:0] dat, input logic [15:0] tid);
        sreq.cyc = 1'b1; sreq.stb = 1'b1; sreq.we = 1'b1;
        sreq.adr = adr;  sreq.sel = sel;  sreq.dat = dat; sreq.tid = tid;
    endtask

    task automatic drop();
        sreq.cyc = 1'b0; sreq.stb = 1'b0; sreq.we = 1'b0;
    endtask

    function automatic logic [255:0] mk(input logic [63:0] l3, input logic [63:0] l2,
                                        input logic [63:0] l1, input logic [63:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] pick(input int kind, input logic [3:0] idx);
        case (kind)
            K_PTBR:   return ptbr;
            K_PTATTR: return ptattr;
            K_RSET:   return 64'(pbl_regset);
            K_PBL:    return pbl[idx];
            default:  return 64'(fault_clr);
        endcase
    endfunction

    initial begin
        int acks;

        vecs[0]  = '{14'h3F20, 32'hFF00_FF00, mk(64'hA5A5_0000_0000_0007, 0, 64'h1234_5000, 0), K_PTBR,   4'd0,  64'h1234_5000};
        vecs[1]  = '{14'h3F20, 32'hFF00_FF00, mk(64'hA5A5_0000_0000_0007, 0, 64'h1234_5000, 0), K_PTATTR, 4'd0,  64'hA5A5_0000_0000_0007};
        vecs[2]  = '{14'h3F24, 32'h0000_0300, mk(0, 0, 64'hFFFF_FFFF_FFFF_BBAA, 0),             K_PTBR,   4'd0,  64'h1234_BBAA};
        vecs[3]  = '{14'h3F60, 32'h0000_0100, mk(0, 0, 64'hFF, 0),                              K_RSET,   4'd0,  64'h1F};
        vecs[4]  = '{14'h3F60, 32'h0000_0001, mk(0, 0, 64'h03, 64'h03),                         K_RSET,   4'd0,  64'h1F};
        vecs[5]  = '{14'h3B20, 32'hFFFF_FFFF, mk(64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111), K_PBL, 4'd5, 64'h2222_2222_2222_2222};
        vecs[6]  = '{14'h3B00, 32'h0000_00FF, mk(0, 0, 0, 64'hAB),                              K_PBL,    4'd0,  64'hAB};
        vecs[7]  = '{14'h3B60, 32'hFF00_0000, mk(64'hDEAD_BEEF_0000_0001, 0, 0, 0),             K_PBL,    4'd15, 64'hDEAD_BEEF_0000_0001};
        vecs[8]  = '{14'h3B00, 32'h0000_0000, mk(0, 0, 0, 64'hFFFF),                            K_PBL,    4'd0,  64'hAB};
        vecs[9]  = '{14'h1000, 32'hFFFF_FFFF, {256{1'b1}},                                      K_PTBR,   4'd0,  64'h1234_BBAA};
        vecs[10] = '{14'h3F00, 32'h0000_0001, mk(0, 0, 0, 0),                                   K_FCLR,   4'd0,  64'h1};
        vecs[11] = '{14'h3F00, 32'h0000_0000, mk(0, 0, 0, 0),                                   K_FCLR,   4'd0,  64'h0};
        vecs[12] = '{14'h3B40, 32'h00FF_0000, mk(0, 64'h77, 0, 0),                              K_PBL,    4'd10, 64'h77};

        rst = 1'b0;
        sreq = '0;
        xlat_ack = 1'b0;
        xlat_padr = '0;
        tick(); tick();
        chk("reset_outputs", 64'({cs_config, cs_regs, wr_ack, fault_clr, xlat_req, phys_adr_v}), 64'h0);
        chk("reset_ptbr", ptbr, 64'h0);
        chk("reset_pbl_or", 64'(|pbl), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven register writes
        for (int i = 0; i < 13; i++) begin
            drive_wr(REG_B + 32'(vecs[i].off), vecs[i].sel, vecs[i].dat, 16'(16'h100 + i));
            tick();
            chk($sformatf("v%0d_ack", i), 64'(wr_ack), 64'h1);
            chk($sformatf("v%0d_tid", i), 64'(wr_tid), 64'(16'h100 + i));
            chk($sformatf("v%0d_cs_regs", i), 64'(cs_regs), 64'h1);
            chk($sformatf("v%0d_value", i), pick(vecs[i].kind, vecs[i].idx), vecs[i].exp);
            drop();
            tick();
            chk($sformatf("v%0d_ack_drop", i), 64'({wr_ack, fault_clr}), 64'h0);
        end
        chk("pbl4", pbl[4], 64'h1111_1111_1111_1111);
        chk("pbl7", pbl[7], 64'h4444_4444_4444_4444);
        chk("pbl1_3_kept", 64'(|{pbl[1], pbl[2], pbl[3]}), 64'h0);

        // Strobe held for 4 cycles gives a single ack
        acks = 0;
        drive_wr(REG_B + 32'h3F60, 32'h0, '0, 16'h0077);
        repeat (4) begin tick(); acks += int'(wr_ack); end
        drop();
        repeat (2) begin tick(); acks += int'(wr_ack); end
        chk("hold_one_ack", 64'(acks), 64'h1);

        // Config window: select only, never acked
        sreq.cyc = 1'b1; sreq.stb = 1'b1; sreq.we = 1'b0; sreq.adr = CFG_B;
        tick();
        chk("cfg_rd_sel", 64'({cs_config, cs_regs, wr_ack}), 64'b100);
        drop(); tick();
        drive_wr(CFG_B + 32'h1FF8, 32'hFFFF_FFFF, '1, 16'h00C0);
        tick();
        chk("cfg_wr_noack", 64'({cs_config, cs_regs, wr_ack}), 64'b100);
        drop(); tick();

        // Probe: launch, walker answers 5 cycles later
        drive_wr(REG_B + 32'h3F40, 32'h0000_00FF, mk(0, 0, 0, 64'h4000), 16'h0200);
        tick();
        chk("probe_req", 64'({xlat_req, phys_adr_v}), 64'b10);
        chk("probe_vadr", virt_adr, 64'h4000);
        drop();
        repeat (4) tick();
        xlat_ack = 1'b1; xlat_padr = 64'h9000;
        tick();
        xlat_ack = 1'b0;
        chk("probe_padr", phys_adr, 64'h9000);
        chk("probe_done", 64'({xlat_req, phys_adr_v}), 64'b01);
        tick();
        chk("probe_v_hold", 64'(phys_adr_v), 64'h1);

        // Walker ack outside REQ is ignored
        xlat_ack = 1'b1; xlat_padr = 64'h1111;
        tick();
        xlat_ack = 1'b0;
        chk("ack_idle_ignored", phys_adr, 64'h9000);
        chk("ack_idle_flags", 64'({xlat_req, phys_adr_v}), 64'b01);

        // Relaunch coincident with walker ack: launch wins
        drive_wr(REG_B + 32'h3F40, 32'h0000_00FF, mk(0, 0, 0, 64'h5000), 16'h0201);
        tick();
        drop();
        chk("relaunch_req", 64'({xlat_req, phys_adr_v}), 64'b10);
        tick(); tick();
        xlat_ack = 1'b1; xlat_padr = 64'hAAAA;
        drive_wr(REG_B + 32'h3F40, 32'h0000_00FF, mk(0, 0, 0, 64'h6000), 16'h0202);
        tick();
        xlat_ack = 1'b0;
        drop();
        chk("race_flags", 64'({xlat_req, phys_adr_v}), 64'b10);
        chk("race_padr_kept", phys_adr, 64'h9000);
        chk("race_vadr", virt_adr, 64'h6000);
        tick(); tick();
        xlat_ack = 1'b1; xlat_padr = 64'hBBBB;
        tick();
        xlat_ack = 1'b0;
        chk("race_final_padr", phys_adr, 64'hBBBB);
        chk("race_final_flags", 64'({xlat_req, phys_adr_v}), 64'b01);

        // Asynchronous reset while a probe is outstanding
        drive_wr(REG_B + 32'h3F40, 32'h0000_00FF, mk(0, 0, 0, 64'h7000), 16'h0203);
        tick();
        drop();
        chk("rst_pre_req", 64'(xlat_req), 64'h1);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_async_flags", 64'({xlat_req, phys_adr_v, wr_ack, cs_regs}), 64'h0);
        chk("rst_async_regs", ptbr | ptattr | virt_adr | phys_adr | 64'(pbl_regset), 64'h0);
        chk("rst_async_pbl", 64'(|pbl), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_wr(REG_B + 32'h3F20, 32'h0000_FF00, mk(0, 0, 64'h55, 0), 16'hBEEF);
        tick();
        chk("post_rst_ack", 64'({wr_ack, wr_tid}), 64'h1BEEF);
        chk("post_rst_ptbr", ptbr, 64'h55);
        drop();
        xlat_ack = 1'b1; xlat_padr = 64'h1;
        tick();
        xlat_ack = 1'b0;
        chk("post_rst_idle", 64'({xlat_req, phys_adr_v}), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmu_reg_write.md
MMU_REG_WRITE -- requirements
Module: mmu_reg_write

Interface
REQ-001 SHALL have parameter CFG_BASE, default 32'hFFD00000: base address of the 8 kB config-space window.
REQ-002 SHALL have parameter REG_BASE, default 32'hFFD10000: base address of the 16 kB MMU register window.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sreq  input  wb_cmd_request256_t  slave bus request (cyc, stb, we, sel[31:0], adr, dat[255:0], tid).
REQ-006 cs_config  output  1  registered config-window select, consumed by the read stage.
REQ-007 cs_regs  output  1  registered register-window select, consumed by the read stage.
REQ-008 wr_ack  output  1  one-cycle write acknowledge.
REQ-009 wr_tid  output  16  tid of the acknowledged write.
REQ-010 ptbr  output  ptbr_t  page-table base register.
REQ-011 ptattr  output  ptattr_t  page-table attributes.
REQ-012 virt_adr  output  virtual_address_t  probe address.
REQ-013 pbl_regset  output  5  pebble register-set select.
REQ-014 pbl  output  pebble_t[15:0]  pebble array.
REQ-015 fault_clr  output  1  one-cycle pulse that clears the fault registers.
REQ-016 xlat_req  output  1  translation probe request to the walker.
REQ-017 xlat_ack, xlat_padr  input  1, physical_address_t  walker completion and result.
REQ-018 phys_adr, phys_adr_v  output  physical_address_t, 1  probe result and its valid flag.

Function
REQ-019 Select: sel_cfg = cyc & stb & adr in [CFG_BASE, CFG_BASE+8K); sel_reg likewise for [REG_BASE, REG_BASE+16K); cs_config and cs_regs SHALL register these with 1-cycle latency; the two selects are never both 1.
REQ-020 Accept: a write SHALL be accepted on the first cycle where sel_reg & we holds; it is decoded on adr[13:0], and byte lanes are merged per sel[31:0].
REQ-021 No re-accept: the same bus cycle SHALL NOT be accepted again until stb deasserts.
REQ-022 wr_ack SHALL pulse for exactly 1 cycle, 1 cycle after accept, with wr_tid = accepted tid; config-window writes are not acked here.
REQ-023 Decode 0x3F00-0x3F1F: a write with any sel bit set SHALL pulse fault_clr; there is no other state change.
REQ-024 Decode 0x3F20-0x3F3F: bytes 8-15 SHALL write ptbr and bytes 24-31 SHALL write ptattr.
REQ-025 Decode 0x3F40-0x3F5F: a write to bytes 0-7 SHALL write virt_adr and launch a probe.
REQ-026 Decode 0x3F60-0x3F7F: byte 8 bits [4:0] SHALL write pbl_regset.
REQ-027 Decode 0x3B00-0x3B7F: each write SHALL write 4 pebbles, index = adr[6:5]*4 + lane (64-bit lanes).
REQ-028 Decode: any other address SHALL be acked and otherwise ignored.
REQ-029 Probe FSM states are IDLE, REQ and DONE.
REQ-030 IDLE->REQ on a probe launch: phys_adr_v cleared, xlat_req set.
REQ-031 REQ->DONE on xlat_ack: phys_adr <= xlat_padr, xlat_req cleared.
REQ-032 DONE: phys_adr_v set; the FSM returns to IDLE the next cycle; phys_adr_v holds until the next launch.
REQ-033 A virt_adr write while in REQ SHALL update virt_adr, keep xlat_req high and restart the probe; a later xlat_ack captures the walker result.
REQ-034 When xlat_ack and a new launch occur in the same cycle, the launch SHALL win: the FSM stays in REQ and phys_adr_v stays 0.
REQ-035 xlat_ack SHALL be ignored outside REQ.

Reset
REQ-036 On rst low, immediately: all outputs 0; FSM in IDLE; any pending ack dropped; no ack is generated for a write interrupted by reset.
REQ-037 On rst release, the first accept SHALL be possible on the first rising edge with rst high.

Structure
REQ-038 The probe state enum and the register-offset constants SHALL live in mmu_pkg alongside ptbr_t, ptattr_t and pebble_t.
REQ-039 The probe FSM SHALL be sub-module mmu_probe_fsm; decode and the register file stay in the top level.

Verification
REQ-040 Write adr REG_BASE+0x3F20, sel=32'hFF00FF00, ptbr data 64'h1234_5000 -> ptbr=64'h1234_5000, ptattr updated, wr_ack 1 cycle after accept with matching tid.
REQ-041 Write virt_adr 64'h4000 -> xlat_req=1; xlat_ack after 5 cycles with padr 64'h9000 -> phys_adr=64'h9000, phys_adr_v=1, xlat_req=0.
REQ-042 Second virt_adr write in the same cycle as xlat_ack -> phys_adr_v stays 0 and xlat_req stays 1.
REQ-043 Write to 0x3B20 with 4 lanes -> pbl[4..7] updated and pbl[0..3] unchanged; sel=0 write -> no change, ack still given.
REQ-044 Hold stb for 4 cycles on one write -> exactly one wr_ack; read at CFG_BASE -> cs_config=1, cs_regs=0, no wr_ack.
REQ-045 Assert rst low while in REQ -> xlat_req, phys_adr_v and all registers 0 asynchronously; FSM in IDLE.
